// File: rtl/ucie_ctl_err_logger_if.sv
// Register-file write port: ready/valid address + data.
// The master issues writes, the slave (register file) accepts them.
interface ucie_ctl_err_logger_if #(
  parameter int ADDR_W = 8
);
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              ready;

  modport master (
    output wr,
    output addr,
    output wdata,
    input  ready
  );

  modport slave (
    input  wr,
    input  addr,
    input  wdata,
    output ready
  );
endinterface

// File: rtl/ucie_ctl_err_logger.sv
// Error-source logger: sticky pending bits and saturating counts per
// register, flushed round-robin over a ready/valid register write port.
module ucie_ctl_err_logger #(
  parameter int          NUM_REG      = 4,
  parameter int          BITS_PER_REG = 8,
  parameter int          ADDR_W       = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h24
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [NUM_REG*BITS_PER_REG-1:0] i_err_src,
  input  logic [NUM_REG*BITS_PER_REG-1:0] i_err_mask,
  input  logic                            i_log_en,
  ucie_ctl_err_logger_if.master           bus,
  output logic                            o_pending_any,
  output logic [NUM_REG-1:0]              o_cnt_sat
);

  localparam int NB = NUM_REG * BITS_PER_REG;
  localparam int LW = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic [0:0]        state;
  logic [LW-1:0]     last;
  logic [LW-1:0]     sel;
  logic [NB-1:0]     src_q;
  logic              take;
  logic              accept;

  logic [NUM_REG-1:0][BITS_PER_REG-1:0] pend;
  logic [NUM_REG-1:0][BITS_PER_REG-1:0] pend_n;
  logic [NUM_REG-1:0][BITS_PER_REG-1:0] edges;
  logic [NUM_REG-1:0][7:0]              cnt;
  logic [NUM_REG-1:0][7:0]              cnt_n;

  logic [NUM_REG-1:0] dirty;
  logic [NUM_REG-1:0] sat_set;
  logic [NUM_REG-1:0] sat_clr;

  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W-1:0] addr_n;
  logic [31:0]       wdata_n;

  function automatic logic [4:0] popcnt(
    input logic [BITS_PER_REG-1:0] v
  );
    logic [4:0] p;
    p = '0;
    for (int i = 0; i < BITS_PER_REG; i++)
      p = p + 5'(v[i]);
    return p;
  endfunction

  function automatic logic [7:0] sat_add(
    input logic [7:0] c,
    input logic [4:0] p
  );
    logic [8:0] s;
    s = {1'b0, c} + {4'b0, p};
    return s[8] ? 8'hff : s[7:0];
  endfunction

  assign edges = i_err_src & ~src_q & ~i_err_mask;

  always_comb begin
    for (int r = 0; r < NUM_REG; r++)
      dirty[r] = |pend[r];
  end

  assign o_pending_any = |dirty;

  // Highest k processed last would lose; iterate downward so the
  // nearest dirty register after `last` wins.
  always_comb begin
    int            idx;
    logic [LW-1:0] ix;
    sel = last;
    idx = 0;
    ix  = '0;
    for (int k = NUM_REG; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= NUM_REG)
        idx = idx - NUM_REG;
      ix = LW'(idx);
      if (dirty[ix])
        sel = ix;
    end
  end

  assign take   = (state == IDLE) && i_log_en && (|dirty);
  assign accept = (state == ISSUE) && bus.ready;

  // Selected register reloads with this cycle's edges only, so no
  // event arriving during the snapshot is dropped.
  always_comb begin
    pend_n  = pend;
    cnt_n   = cnt;
    sat_set = '0;
    for (int r = 0; r < NUM_REG; r++) begin
      if (take && sel == LW'(r)) begin
        pend_n[r] = edges[r];
        cnt_n[r]  = {3'b0, popcnt(edges[r])};
      end else begin
        pend_n[r]  = pend[r] | edges[r];
        cnt_n[r]   = sat_add(cnt[r], popcnt(edges[r]));
        sat_set[r] = (cnt[r] != 8'hff) && (cnt_n[r] == 8'hff);
      end
    end
  end

  always_comb begin
    sat_clr = '0;
    if (accept)
      sat_clr[last] = 1'b1;
  end

  always_comb begin
    wdata_n                    = '0;
    wdata_n[31:24]             = cnt[sel];
    wdata_n[BITS_PER_REG-1:0]  = pend[sel];
    addr_n = ADDR_W'(BASE_ADDR + 32'(sel) * 32'd4);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      last      <= LW'(NUM_REG - 1);
      src_q     <= '0;
      pend      <= '0;
      cnt       <= '0;
      o_cnt_sat <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      src_q     <= i_err_src;
      pend      <= pend_n;
      cnt       <= cnt_n;
      o_cnt_sat <= (o_cnt_sat & ~sat_clr) | sat_set;
      case (state)
        IDLE: begin
          if (take) begin
            state   <= ISSUE;
            last    <= sel;
            wr_q    <= 1'b1;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
          end
        end
        ISSUE: begin
          if (bus.ready) begin
            state <= IDLE;
            wr_q  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wr    = wr_q;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;

endmodule
